// File: rtl/clock_counter_if.sv
// ----------------------------------------------------------------------------
// clock_counter_if
// Strobe / field bundle between the clock control FSM and the time-of-day
// counter.
//
//   Strobes (FSM -> counter):
//     i_ms_up, i_ms_down       ms advance / synchronous clear (level)
//     i_sec_up, i_sec_down     second increment / decrement
//     i_min_up, i_min_down     minute increment / decrement
//     i_hr_up,  i_hr_down      hour increment / decrement
//   Fields and carries (counter -> FSM / display):
//     o_ms, o_sec, o_min, o_hr registered field values
//     o_ms_carryup, o_sec_carryup, o_min_carryup  combinational wrap-up flags
//
//   modport master : the strobe source (clock control FSM / testbench)
//   modport slave  : the counter itself
// ----------------------------------------------------------------------------
interface clock_counter_if #(
    parameter int unsigned MS_W = 10
);
    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    // Strobes
    logic              i_ms_up;
    logic              i_ms_down;
    logic              i_sec_up;
    logic              i_sec_down;
    logic              i_min_up;
    logic              i_min_down;
    logic              i_hr_up;
    logic              i_hr_down;

    // Field values
    logic [MS_W-1:0]   o_ms;
    logic [SEC_W-1:0]  o_sec;
    logic [MIN_W-1:0]  o_min;
    logic [HR_W-1:0]   o_hr;

    // Carry-up flags, valid in the same cycle as the causing strobe
    logic              o_ms_carryup;
    logic              o_sec_carryup;
    logic              o_min_carryup;

    modport master (
        output i_ms_up, i_ms_down,
        output i_sec_up, i_sec_down,
        output i_min_up, i_min_down,
        output i_hr_up, i_hr_down,
        input  o_ms, o_sec, o_min, o_hr,
        input  o_ms_carryup, o_sec_carryup, o_min_carryup
    );

    modport slave (
        input  i_ms_up, i_ms_down,
        input  i_sec_up, i_sec_down,
        input  i_min_up, i_min_down,
        input  i_hr_up, i_hr_down,
        output o_ms, o_sec, o_min, o_hr,
        output o_ms_carryup, o_sec_carryup, o_min_carryup
    );

endinterface : clock_counter_if

// File: rtl/clock_counter.sv
// ----------------------------------------------------------------------------
// clock_counter
// Time-of-day counter (ms / second / minute / hour) for the refined clock.
// Each field is an independent binary register stepped by its own up/down
// strobe pair from the clock control FSM. The block has no mode knowledge:
// carry-up flags are returned combinationally and the FSM chains them into
// the next field's up strobe, so a full 23:59:59.999 -> 00:00:00.000
// rollover lands on a single edge. Decrement wraps never borrow.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rstn  asynchronous active-low reset, clears every field
//   bus     clock_counter_if.slave (strobes in, fields and carries out)
//
// Parameters:
//   MS_MAX  terminal ms value (ms wraps MS_MAX -> 0)
//   MS_W    ms field width, 2**MS_W > MS_MAX
//   HR_MAX  terminal hour value
// ----------------------------------------------------------------------------
module clock_counter #(
    parameter int unsigned MS_MAX = 999,
    parameter int unsigned MS_W   = 10,
    parameter int unsigned HR_MAX = 23
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    clock_counter_if.slave  bus
);

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HR_W   = 5;
    localparam int unsigned SM_MAX = 59;

    localparam logic [MS_W-1:0]  MS_TOP  = MS_W'(MS_MAX);
    localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SM_MAX);
    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(SM_MAX);
    localparam logic [HR_W-1:0]  HR_TOP  = HR_W'(HR_MAX);

    // ------------------------------------------------------------------------
    // Field registers
    // ------------------------------------------------------------------------
    logic [MS_W-1:0]  ms_q,  ms_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q,  hr_d;

    // Qualified step requests; conflicting up+down collapses to hold
    // (or to clear for the ms field, where down dominates).
    logic ms_inc;
    logic ms_clr;
    logic sec_inc, sec_dec;
    logic min_inc, min_dec;
    logic hr_inc,  hr_dec;

    // ------------------------------------------------------------------------
    // Field step helpers. Out-of-range values (unreachable from reset) are
    // treated as the terminal value so the field always recovers in range.
    // ------------------------------------------------------------------------
    function automatic logic [SEC_W-1:0] step_sec(
        input logic [SEC_W-1:0] val,
        input logic             inc,
        input logic             dec
    );
        logic [SEC_W-1:0] nxt;
        nxt = val;
        if (inc) begin
            nxt = (val >= SEC_TOP) ? '0 : val + SEC_W'(1);
        end else if (dec) begin
            nxt = (val == '0 || val > SEC_TOP) ? SEC_TOP : val - SEC_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [MIN_W-1:0] step_min(
        input logic [MIN_W-1:0] val,
        input logic             inc,
        input logic             dec
    );
        logic [MIN_W-1:0] nxt;
        nxt = val;
        if (inc) begin
            nxt = (val >= MIN_TOP) ? '0 : val + MIN_W'(1);
        end else if (dec) begin
            nxt = (val == '0 || val > MIN_TOP) ? MIN_TOP : val - MIN_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [HR_W-1:0] step_hr(
        input logic [HR_W-1:0] val,
        input logic            inc,
        input logic            dec
    );
        logic [HR_W-1:0] nxt;
        nxt = val;
        if (inc) begin
            nxt = (val >= HR_TOP) ? '0 : val + HR_W'(1);
        end else if (dec) begin
            nxt = (val == '0 || val > HR_TOP) ? HR_TOP : val - HR_W'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------------
    // Strobe qualification
    // ------------------------------------------------------------------------
    always_comb begin
        ms_clr  = bus.i_ms_down;
        ms_inc  = bus.i_ms_up & ~bus.i_ms_down;
        sec_inc = bus.i_sec_up & ~bus.i_sec_down;
        sec_dec = bus.i_sec_down & ~bus.i_sec_up;
        min_inc = bus.i_min_up & ~bus.i_min_down;
        min_dec = bus.i_min_down & ~bus.i_min_up;
        hr_inc  = bus.i_hr_up & ~bus.i_hr_down;
        hr_dec  = bus.i_hr_down & ~bus.i_hr_up;
    end

    // ------------------------------------------------------------------------
    // Next-state for all fields
    // ------------------------------------------------------------------------
    always_comb begin
        ms_d  = ms_q;
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;

        // ms: clear dominates; no decrement, only advance with wrap
        if (ms_clr) begin
            ms_d = '0;
        end else if (ms_inc) begin
            ms_d = (ms_q >= MS_TOP) ? '0 : ms_q + MS_W'(1);
        end

        sec_d = step_sec(sec_q, sec_inc, sec_dec);
        min_d = step_min(min_q, min_inc, min_dec);
        hr_d  = step_hr(hr_q, hr_inc, hr_dec);
    end

    // ------------------------------------------------------------------------
    // Field register bank
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ms_q  <= '0;
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            ms_q  <= ms_d;
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: fields straight from registers, carries combinational so the
    // upstream chain resolves within one cycle. Carry uses an exact terminal
    // compare; it only depends on this field's own strobes, keeping the
    // upstream ms -> sec -> min -> hr chain acyclic.
    // ------------------------------------------------------------------------
    assign bus.o_ms  = ms_q;
    assign bus.o_sec = sec_q;
    assign bus.o_min = min_q;
    assign bus.o_hr  = hr_q;

    assign bus.o_ms_carryup  = ms_inc  & (ms_q  == MS_TOP);
    assign bus.o_sec_carryup = sec_inc & (sec_q == SEC_TOP);
    assign bus.o_min_carryup = min_inc & (min_q == MIN_TOP);

endmodule : clock_counter

// File: tb/tb_clock_counter.sv
// ----------------------------------------------------------------------------
// tb_clock_counter
// Self-checking bench for clock_counter. A time-of-day reference model kept
// as plain integers (modular arithmetic) predicts fields and carries. The
// bench can optionally chain the DUT carries into the next field's up strobe,
// the way the clock control FSM does upstream.
// ----------------------------------------------------------------------------
module tb_clock_counter;

    localparam int unsigned MS_MAX = 999;
    localparam int unsigned MS_W   = 10;
    localparam int unsigned HR_MAX = 23;

    // Strobe bit positions in an 8-bit stimulus word
    localparam logic [7:0] S_MSU = 8'h80;
    localparam logic [7:0] S_MSD = 8'h40;
    localparam logic [7:0] S_SU  = 8'h20;
    localparam logic [7:0] S_SD  = 8'h10;
    localparam logic [7:0] S_MU  = 8'h08;
    localparam logic [7:0] S_MD  = 8'h04;
    localparam logic [7:0] S_HU  = 8'h02;
    localparam logic [7:0] S_HD  = 8'h01;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    clock_counter_if #(.MS_W(MS_W)) bus ();

    clock_counter #(
        .MS_MAX (MS_MAX),
        .MS_W   (MS_W),
        .HR_MAX (HR_MAX)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    // Raw up strobes; chain ORs in the DUT carry like the upstream FSM
    logic sec_up_r = 1'b0;
    logic min_up_r = 1'b0;
    logic hr_up_r  = 1'b0;
    logic chain    = 1'b0;

    assign bus.i_sec_up = sec_up_r | (chain & bus.o_ms_carryup);
    assign bus.i_min_up = min_up_r | (chain & bus.o_sec_carryup);
    assign bus.i_hr_up  = hr_up_r  | (chain & bus.o_min_carryup);

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Reference model: time-of-day as plain integers
    int m_ms  = 0;
    int m_sec = 0;
    int m_min = 0;
    int m_hr  = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s got=%0d exp=%0d t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input bit up, input bit dn, input int modulus);
        if (up && !dn) return (v + 1) % modulus;
        if (dn && !up) return (v + modulus - 1) % modulus;
        return v;
    endfunction

    task automatic drive(input logic [7:0] s);
        bus.i_ms_up    = s[7];
        bus.i_ms_down  = s[6];
        sec_up_r       = s[5];
        bus.i_sec_down = s[4];
        min_up_r       = s[3];
        bus.i_min_down = s[2];
        hr_up_r        = s[1];
        bus.i_hr_down  = s[0];
    endtask

    task automatic check_fields();
        check("ms",  int'(bus.o_ms),  m_ms);
        check("sec", int'(bus.o_sec), m_sec);
        check("min", int'(bus.o_min), m_min);
        check("hr",  int'(bus.o_hr),  m_hr);
    endtask

    // One clock cycle: apply strobes, check same-cycle carries, then fields.
    task automatic step(input logic [7:0] s);
        bit c_ms, c_sec, c_min;
        bit su, mu, hu;
        @(negedge clk);
        drive(s);
        #1;
        c_ms  = s[7] && !s[6] && (m_ms == MS_MAX);
        su    = s[5] || (chain && c_ms);
        c_sec = su && !s[4] && (m_sec == 59);
        mu    = s[3] || (chain && c_sec);
        c_min = mu && !s[2] && (m_min == 59);
        hu    = s[1] || (chain && c_min);
        check("ms_carry",  int'(bus.o_ms_carryup),  int'(c_ms));
        check("sec_carry", int'(bus.o_sec_carryup), int'(c_sec));
        check("min_carry", int'(bus.o_min_carryup), int'(c_min));
        @(posedge clk);
        m_ms  = s[6] ? 0 : (s[7] ? (m_ms + 1) % (MS_MAX + 1) : m_ms);
        m_sec = bump(m_sec, su,   s[4], 60);
        m_min = bump(m_min, mu,   s[2], 60);
        m_hr  = bump(m_hr,  hu,   s[0], HR_MAX + 1);
        #1;
        check_fields();
    endtask

    // Async reset asserted mid-cycle while strobes s are held.
    task automatic async_reset(input logic [7:0] s);
        @(negedge clk);
        drive(s);
        #2;
        rstn = 1'b0;
        #1;
        m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
        check_fields();
        check("rst_ms_carry",  int'(bus.o_ms_carryup),  0);
        check("rst_sec_carry", int'(bus.o_sec_carryup), 0);
        check("rst_min_carry", int'(bus.o_min_carryup), 0);
        @(posedge clk);
        #1;
        check("rst_hold_ms", int'(bus.o_ms), 0);
        drive(8'h00);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_sec;
        drive(8'h00);

        // Reset from power-up
        phase = "por";
        async_reset(8'h00);

        // Reset mid-count at ms=517
        phase = "rst_mid";
        repeat (517) step(S_MSU);
        check("ms_517", int'(bus.o_ms), 517);
        async_reset(S_MSU);
        step(S_MSU);
        check("ms_after_rst", int'(bus.o_ms), 1);

        // ms wrap with carry chained into seconds
        phase = "ms_wrap";
        async_reset(8'h00);
        chain = 1'b1;
        repeat (999) step(S_MSU);
        check("ms_999", int'(bus.o_ms), 999);
        step(S_MSU);
        check("wrap_ms",  int'(bus.o_ms),  0);
        check("wrap_sec", int'(bus.o_sec), 1);

        // Decrement wraps, no borrow
        phase = "dec_wrap";
        chain = 1'b0;
        step(S_SD);
        repeat (5) step(S_MU);
        step(S_SD);
        check("sec_59", int'(bus.o_sec), 59);
        check("min_5",  int'(bus.o_min), 5);
        step(S_HD);
        check("hr_23", int'(bus.o_hr), 23);

        // Simultaneous up+down
        phase = "simul";
        step(S_SU | S_SD);
        check("sec_hold_59", int'(bus.o_sec), 59);
        repeat (999) step(S_MSU);
        step(S_MSU | S_MSD);
        check("ms_clr_dom", int'(bus.o_ms), 0);

        // Full rollover 23:59:59.999 -> 00:00:00.000
        phase = "rollover";
        async_reset(8'h00);
        step(S_HD);
        step(S_MD);
        step(S_SD);
        repeat (999) step(S_MSU);
        chain = 1'b1;
        step(S_MSU);
        check("roll_ms",  int'(bus.o_ms),  0);
        check("roll_sec", int'(bus.o_sec), 0);
        check("roll_min", int'(bus.o_min), 0);
        check("roll_hr",  int'(bus.o_hr),  0);

        // Clear held while up pulses every cycle
        phase = "clr_hold";
        repeat (7) step(S_MSU);
        saved_sec = int'(bus.o_sec);
        repeat (10) step(S_MSU | S_MSD);
        check("clr_ms",  int'(bus.o_ms),  0);
        check("clr_sec", int'(bus.o_sec), 0);
        check("clr_sec_same", int'(bus.o_sec), saved_sec);

        // Randomized traffic, occasional async reset
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] s;
            s    = 8'($urandom) & 8'($urandom);
            s[7] = ($urandom_range(0, 3) != 0);
            s[6] = ($urandom_range(0, 63) == 0);
            chain = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                async_reset(s);
            end else begin
                step(s);
            end
        end

        chain = 1'b0;
        drive(8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_clock_counter
